// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM states, length encodings and IO-space selector for mem_port_arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, RD, RDLAST, WR} state_e;

  localparam logic [1:0] LEN_1B     = 2'd0;
  localparam logic [1:0] LEN_2B     = 2'd1;
  localparam logic [1:0] LEN_4B     = 2'd2;
  localparam logic [1:0] IO_SEL_DEF = 2'b11;

  // The unused encoding 3 is deliberately treated as a 4-byte access.
  function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
    return len == LEN_1B ? 3'd1 : len == LEN_2B ? 3'd2 : 3'd4;
  endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// mem_arb_picker: combinational rotating-priority grant; the search starts at ptr.
module mem_arb_picker #(
  parameter int NUM_CH = 2,
  parameter int PW     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PW-1:0]     ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [PW-1:0]     gnt_idx,
  output logic              any
);

  // ptr is always below NUM_CH, so one conditional subtract wraps the index.
  function automatic logic [PW-1:0] rot(input logic [PW-1:0] p, input int i);
    int s;
    s = int'(p) + i;
    return PW'(s >= NUM_CH ? s - NUM_CH : s);
  endfunction

  logic [PW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = rot(ptr, i);
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises 1/2/4-byte requests from NUM_CH channels onto the byte-wide RAM/IO port.
// Define FIXED_PRIORITY_EN for strict lowest-index-wins arbitration instead of round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          NUM_CH = 2,
  parameter int          ADDR_W = 32,
  parameter logic [1:0]  IO_SEL = IO_SEL_DEF
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH-1:0]        req_wr,
  input  logic [2*NUM_CH-1:0]      req_len,
  input  logic [ADDR_W*NUM_CH-1:0] req_addr,
  input  logic [32*NUM_CH-1:0]     req_wdata,
  input  logic [NUM_CH-1:0]        flush_mask,
  output logic [NUM_CH-1:0]        resp_done,
  output logic [31:0]              resp_rdata,
  output logic [NUM_CH-1:0]        busy_ch,
  input  logic [7:0]               mem_din,
  output logic [7:0]               mem_dout,
  output logic [ADDR_W-1:0]        mem_a,
  output logic                     mem_wr,
  input  logic                     io_buffer_full
);

  localparam int PW = $clog2(NUM_CH);

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   owner_q, owner_d, gnt;
  logic [PW-1:0]       gnt_idx, ptr;
  logic                any;
  logic [ADDR_W-1:0]   addr_q, addr_d, mem_a_q, mem_a_d;
  logic [2:0]          nb_q, nb_d, idx_q, idx_d;
  logic [31:0]         wdata_q, wdata_d, rdata_q, rdata_d, rd_full;
  logic [7:0]          dout_q, dout_d;
  logic                flushed, stall, wr_act;

  mem_arb_picker #(.NUM_CH(NUM_CH), .PW(PW)) u_picker (
    .req     (req_valid & ~flush_mask),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

`ifdef FIXED_PRIORITY_EN
  assign ptr = '0;
`else
  logic [PW-1:0] ptr_q, ptr_d;
  assign ptr = ptr_q;
  always_comb ptr_d = state_q == IDLE && any ? (gnt_idx == PW'(NUM_CH - 1) ? '0 : gnt_idx + 1'b1) : ptr_q;
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) ptr_q <= '0;
    else if (rdy_in) ptr_q <= ptr_d;
`endif

  assign flushed = |(flush_mask & owner_q);
  assign stall   = addr_q[17:16] == IO_SEL && io_buffer_full;
  // WR keeps one extra cycle once every byte is out (idx == nb) to pulse done.
  assign wr_act  = state_q == WR && idx_q != nb_q;
  // The last read byte arrives during RDLAST and is merged without being registered.
  assign rd_full = rdata_q | (32'(mem_din) << {nb_q - 3'd1, 3'b000});

  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) state_q <= IDLE;
    else if (rdy_in) state_q <= state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = any ? (req_wr[gnt_idx] ? WR : RD) : IDLE;
      RD:      state_d = flushed ? IDLE : idx_q == nb_q - 3'd1 ? RDLAST : RD;
      RDLAST:  state_d = IDLE;
      WR:      state_d = wr_act ? WR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_a      = state_q == RD || wr_act ? addr_q + ADDR_W'(idx_q) : mem_a_q;
    mem_dout   = wr_act ? wdata_q[{idx_q[1:0], 3'b000} +: 8] : dout_q;
    mem_wr     = rdy_in && wr_act && !stall;
    resp_done  = rdy_in && ((state_q == RDLAST && !flushed) || (state_q == WR && !wr_act)) ? owner_q : '0;
    resp_rdata = state_q == RDLAST && |resp_done ? rd_full : '0;
    busy_ch    = state_q == IDLE ? '0 : owner_q;
  end

  always_comb begin
    owner_d = owner_q;
    addr_d  = addr_q;
    nb_d    = nb_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_a_d = mem_a;
    dout_d  = mem_dout;
    if (state_q == IDLE && any) begin
      owner_d = gnt;
      idx_d   = '0;
      rdata_d = '0;
      for (int i = 0; i < NUM_CH; i++)
        if (gnt[i]) begin
          addr_d  = req_addr[i*ADDR_W +: ADDR_W];
          nb_d    = len_to_bytes(req_len[i*2 +: 2]);
          wdata_d = req_wdata[i*32 +: 32];
        end
    end else if (state_q == RD) begin
      idx_d = idx_q + 3'd1;
      if (idx_q != 3'd0) rdata_d[{idx_q[1:0] - 2'd1, 3'b000} +: 8] = mem_din;
    end else if (wr_act && !stall) begin
      idx_d = idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      owner_q <= '0;
      addr_q  <= '0;
      nb_q    <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mem_a_q <= '0;
      dout_q  <= '0;
    end else if (rdy_in) begin
      owner_q <= owner_d;
      addr_q  <= addr_d;
      nb_q    <= nb_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mem_a_q <= mem_a_d;
      dout_q  <= dout_d;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a done/write scoreboard for mem_port_arbiter.
module tb_mem_port_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;

  logic            clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, io_buffer_full = 1'b0;
  logic [N-1:0]    req_valid = '0, req_wr = '0, flush_mask = '0;
  logic [2*N-1:0]  req_len = '0;
  logic [AW*N-1:0] req_addr = '0;
  logic [32*N-1:0] req_wdata = '0;
  logic [N-1:0]    resp_done, busy_ch;
  logic [31:0]     resp_rdata;
  logic [7:0]      mem_din, mem_dout;
  logic [AW-1:0]   mem_a;
  logic            mem_wr;

  mem_port_arbiter #(.NUM_CH(N), .ADDR_W(AW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .req_valid(req_valid), .req_wr(req_wr),
    .req_len(req_len), .req_addr(req_addr), .req_wdata(req_wdata), .flush_mask(flush_mask),
    .resp_done(resp_done), .resp_rdata(resp_rdata), .busy_ch(busy_ch), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0] ram [0:262143];
  always @(posedge clk_in) begin
    mem_din <= ram[mem_a[17:0]];
    if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
  end

  typedef struct { int ch; logic [31:0] rd; bit chk_rd; } exp_t;
  typedef struct { logic [31:0] a; logic [7:0] d; } wexp_t;
  exp_t  dq[$];
  wexp_t wq[$];
  int pass_cnt = 0, tot_cnt = 0, done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_req(input int ch, input bit wr, input logic [1:0] len, input logic [31:0] a, input logic [31:0] wd);
    req_wr[ch]            = wr;
    req_len[2*ch +: 2]    = len;
    req_addr[AW*ch +: AW] = a;
    req_wdata[32*ch +: 32] = wd;
    req_valid[ch]         = 1'b1;
  endtask

  task automatic push_done(input int ch, input logic [31:0] rd, input bit chk_rd);
    exp_t e;
    e.ch = ch; e.rd = rd; e.chk_rd = chk_rd;
    dq.push_back(e);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [7:0] d);
    wexp_t w;
    w.a = a; w.d = d;
    wq.push_back(w);
  endtask

  always @(negedge clk_in) begin
    exp_t  e;
    wexp_t w;
    if (rst_in === 1'b1) begin
      if (|resp_done) begin
        done_cnt++;
        if (dq.size() == 0) chk("unexpected_done", 64'(resp_done), 64'd0);
        else begin
          e = dq.pop_front();
          chk("done_ch", 64'(resp_done), 64'(1) << e.ch);
          if (e.chk_rd) chk("rdata", 64'(resp_rdata), 64'(e.rd));
        end
      end
      if (mem_wr === 1'b1) begin
        if (wq.size() == 0) chk("unexpected_write", 64'(mem_a), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          w = wq.pop_front();
          chk("wr_addr", 64'(mem_a), 64'(w.a));
          chk("wr_data", 64'(mem_dout), 64'(w.d));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 262144; i++) ram[i] = 8'(i * 7 + 3);
    ram[18'h100] = 8'h11; ram[18'h101] = 8'h22; ram[18'h102] = 8'h33; ram[18'h103] = 8'h44;
    ram[18'h200] = 8'hA0; ram[18'h300] = 8'hB0; ram[18'h400] = 8'hC4;
    ram[18'h3FFFF] = 8'hEE; ram[18'h0] = 8'h77;

    #2 rst_in = 1'b0;
    tick();
    @(negedge clk_in);
    chk("rst_mem_a", 64'(mem_a), 0);
    chk("rst_mem_wr", 64'(mem_wr), 0);
    chk("rst_mem_dout", 64'(mem_dout), 0);
    chk("rst_done", 64'(resp_done), 0);
    chk("rst_rdata", 64'(resp_rdata), 0);
    chk("rst_busy", 64'(busy_ch), 0);
    tick();
    rst_in = 1'b1;
    tick();

    // Both channels hold 1-byte read requests; four grants are observed, then both drop.
    set_req(0, 1'b0, 2'd0, 32'h200, 0);
    set_req(1, 1'b0, 2'd0, 32'h300, 0);
`ifdef FIXED_PRIORITY_EN
    for (int i = 0; i < 4; i++) push_done(0, 32'hA0, 1'b1);
`else
    for (int i = 0; i < 2; i++) begin
      push_done(0, 32'hA0, 1'b1);
      push_done(1, 32'hB0, 1'b1);
    end
`endif
    for (int c = 0; c < 100 && done_cnt < 4; c++) begin
      @(negedge clk_in);
      #1;
    end
    chk("arb_four_dones", 64'(done_cnt >= 4), 1);
    tick();
    req_valid = '0;
    tick();

    set_req(1, 1'b0, 2'd2, 32'h100, 0);
    push_done(1, 32'h44332211, 1'b1);
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) tick();
      @(negedge clk_in);
      if (k == 0) chk("rd4_idle_busy", 64'(busy_ch), 0);
      if (k == 1) chk("rd4_busy", 64'(busy_ch), 2);
      if (k >= 1 && k <= 4) chk("rd4_addr", 64'(mem_a), 64'(32'h100 + k - 1));
      if (k >= 1 && k <= 4) chk("rd4_no_wr", 64'(mem_wr), 0);
      if (k == 5) chk("rd4_done_at_6", 64'(resp_done), 2);
    end
    tick();
    req_valid = '0;
    tick();

    set_req(0, 1'b0, 2'd1, 32'hFFFF_FFFF, 0);
    push_done(0, 32'h0000_77EE, 1'b1);
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) tick();
      @(negedge clk_in);
      if (k == 1) chk("wrap_addr0", 64'(mem_a), 64'hFFFF_FFFF);
      if (k == 2) chk("wrap_addr1", 64'(mem_a), 0);
      if (k == 3) chk("wrap_done", 64'(resp_done), 1);
    end
    tick();
    req_valid = '0;
    tick();

    set_req(1, 1'b1, 2'd0, 32'h0003_0000, 32'h41);
    io_buffer_full = 1'b1;
    push_wr(32'h0003_0000, 8'h41);
    push_done(1, 0, 1'b0);
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) tick();
      if (k == 6) io_buffer_full = 1'b0;
      @(negedge clk_in);
      if (k >= 1 && k <= 5) chk("io_stall_wr", 64'(mem_wr), 0);
      if (k == 6) chk("io_wr", 64'(mem_wr), 1);
      if (k == 6) chk("io_dout", 64'(mem_dout), 64'h41);
      if (k == 7) chk("io_done", 64'(resp_done), 2);
    end
    tick();
    req_valid = '0;
    tick();

    set_req(0, 1'b0, 2'd1, 32'h0001_FFFF, 0);
    set_req(1, 1'b0, 2'd0, 32'h400, 0);
    push_done(1, 32'hC4, 1'b1);
    tick();
    flush_mask = 2'b01;
    @(negedge clk_in);
    chk("flush_addr", 64'(mem_a), 64'h0001_FFFF);
    chk("flush_no_done", 64'(resp_done), 0);
    tick();
    flush_mask = '0;
    req_valid[0] = 1'b0;
    @(negedge clk_in);
    chk("flush_idle", 64'(busy_ch), 0);
    tick();
    @(negedge clk_in);
    chk("flush_next_grant", 64'(busy_ch), 2);
    tick();
    @(negedge clk_in);
    chk("flush_ch1_done", 64'(resp_done), 2);
    tick();
    req_valid = '0;
    tick();

    set_req(0, 1'b1, 2'd2, 32'h500, 32'hDDCC_BBAA);
    push_wr(32'h500, 8'hAA);
    push_wr(32'h501, 8'hBB);
    push_wr(32'h502, 8'hCC);
    push_wr(32'h503, 8'hDD);
    push_done(0, 0, 1'b0);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) tick();
      if (k == 3) rdy_in = 1'b0;
      if (k == 6) rdy_in = 1'b1;
      @(negedge clk_in);
      if (k >= 3 && k <= 5) chk("rdy_freeze_wr", 64'(mem_wr), 0);
      if (k >= 3 && k <= 5) chk("rdy_freeze_addr", 64'(mem_a), 64'h502);
      if (k == 6) chk("rdy_resume_addr", 64'(mem_a), 64'h502);
      if (k == 6) chk("rdy_resume_wr", 64'(mem_wr), 1);
      if (k == 8) chk("rdy_done", 64'(resp_done), 1);
    end
    tick();
    req_valid = '0;
    tick();

    set_req(1, 1'b0, 2'd2, 32'h100, 0);
    tick();
    tick();
    rst_in = 1'b0;
    #1;
    chk("arst_mem_a", 64'(mem_a), 0);
    chk("arst_mem_wr", 64'(mem_wr), 0);
    chk("arst_dout", 64'(mem_dout), 0);
    chk("arst_busy", 64'(busy_ch), 0);
    chk("arst_done", 64'(resp_done), 0);
    chk("arst_rdata", 64'(resp_rdata), 0);
    tick();
    req_valid = '0;
    rst_in = 1'b1;
    repeat (8) tick();

    chk("done_queue_empty", 64'(dq.size()), 0);
    chk("write_queue_empty", 64'(wq.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Parametrised successor to the CPU-top memory access glue. Arbitrates NUM_CH requestors (IF, SLB, future D-cache/prefetch) onto the single byte-wide RAM/IO port. Serialises 1/2/4-byte little-endian transactions, stalls IO writes on io_buffer_full and supports per-channel flush on control hazard. Sits between the requestors and the cpu mem_* pins.

Parameters:
NUM_CH, 2, number of requestor channels (>=2); index 0 is IF by convention
ADDR_W, 32, address width
IO_SEL, 2'b11, value of addr[17:16] that marks IO space

Ports:
clk_in  input  1  clock
rst_in  input  1  asynchronous, active-low reset
rdy_in  input  1  global ready; low freezes the block
req_valid  input  NUM_CH  request per channel; held stable until resp_done
req_wr  input  NUM_CH  1=write, 0=read
req_len  input  2*NUM_CH  0=1B, 1=2B, 2=4B (3 treated as 4B)
req_addr  input  ADDR_W*NUM_CH  byte start address
req_wdata  input  32*NUM_CH  write data, byte k at [8k+7:8k]
flush_mask  input  NUM_CH  abort reads of the set channels
resp_done  output  NUM_CH  one-cycle completion pulse
resp_rdata  output  32  read data, zero-extended, valid while resp_done is high
busy_ch  output  NUM_CH  one-hot owner of the current transaction
mem_din  input  8  RAM/IO read byte (1-cycle latency)
mem_dout  output  8  write byte
mem_a  output  ADDR_W  byte address
mem_wr  output  1  write strobe
io_buffer_full  input  1  UART tx buffer full

Behaviour:
- Reset (async, rst_in=0): state IDLE; mem_a=0, mem_wr=0, mem_dout=0, resp_done=0, resp_rdata=0, busy_ch=0, round-robin pointer=0.
- rdy_in=0: all registers hold; mem_wr forced 0; resp_done forced 0.
- FSM states:
  - IDLE: arbitrate among req_valid & ~flush_mask. Winner latched (addr, len, wr, wdata, owner); go to RD or WR. No memory access in the IDLE cycle, which gives a turnaround bubble between transactions.
  - RD: cycle k (k=0..L-1) drives mem_a=addr+k (mod 2^ADDR_W), mem_wr=0. Byte k is captured from mem_din in cycle k+1 into rdata[8k+7:8k]. After the last issue, go to RDLAST.
  - RDLAST: capture the final byte; resp_done[owner]=1 with the assembled resp_rdata; go to IDLE.
  - WR: cycle k drives mem_a=addr+k, mem_dout=wdata byte k, mem_wr=1. If addr[17:16]==IO_SEL and io_buffer_full=1, mem_wr=0 and k holds (stall, unbounded). After the last byte is written: resp_done[owner]=1 the next cycle, then IDLE.
- Latency: read L bytes = 1 (IDLE) + L + 1 cycles from request to done; unstalled write = 1 + L + 1.
- Arbitration: round-robin. The pointer advances to owner+1 on grant; search starts at the pointer.
- flush_mask[owner]=1 during RD/RDLAST: abort. Next state IDLE, no resp_done, mem_wr stays 0. A flush during WR is ignored; the store completes with done asserted.
- A requestor dropping req_valid mid-transaction does not abort it; done still pulses.
- Address increment wraps modulo 2^ADDR_W; no alignment requirement.
- mem_a is held at its last value outside RD/WR. mem_wr is never 1 outside WR.

Optional Feature:
FIXED_PRIORITY_EN. When defined, arbitration is strict priority with the lowest index winning, and the round-robin pointer is removed. When undefined, round-robin as above.

Decomposition:
- Shared package (mem_arb_pkg): state enum {IDLE,RD,RDLAST,WR}, length encodings LEN_1B/LEN_2B/LEN_4B, IO_SEL default, and a len_to_bytes function.
- One sub-module: mem_arb_picker, a combinational round-robin/priority grant from requests and pointer.

Test Plan:
- Ch1 reads 4B at 0x00000100, RAM holds 0x11,0x22,0x33,0x44 -> mem_a steps 0x100..0x103 on consecutive cycles; resp_done[1] 6 cycles after request; resp_rdata=0x44332211.
- Ch0 and ch1 both request 1B reads continuously -> grants alternate 0,1,0,1. With FIXED_PRIORITY_EN, ch0 always wins.
- Ch1 writes 1B 0x41 to 0x30000 with io_buffer_full high for 5 cycles -> mem_wr=0 for those cycles; mem_wr=1 with mem_dout=0x41 in the first cycle io_buffer_full is low; done the next cycle.
- Ch0 2B read at 0x1FFFF, flush_mask[0] asserted during the first RD cycle -> no resp_done; IDLE next cycle; a pending ch1 request is granted after.
- rdy_in low for 3 cycles mid 4B write -> mem_wr=0 and byte index frozen; resumes at the same byte; exactly 4 bytes are written in total.
- rst_in pulsed low mid-read -> all outputs 0 immediately (asynchronous); no resp_done after reset release.
